// File: rtl/hold_sched_pkg.sv
// Shared types and defaults for the round-robin hold-register scheduler.
package hold_sched_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } hold_state_e;

  localparam int N_REQ_DEF       = 4;
  localparam int DW_DEF          = 8;
  localparam int HOLD_CYCLES_DEF = 2;

  // Width of a requester index; kept at least 1 bit so ports never collapse.
  function automatic int src_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hold_reg_sched_rr_pick.sv
// Combinational round-robin picker: first set bit of elig at or above ptr, wrapping.
module rr_pick #(
  parameter int N  = 4,
  parameter int SW = 2
) (
  input  logic [N-1:0]  elig,
  input  logic [SW-1:0] ptr,
  output logic [SW-1:0] grant,
  output logic          any
);

  int j;

  always_comb begin
    grant = '0;
    any   = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      // N need not be a power of two, so wrap explicitly rather than by truncation.
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!any && elig[j]) begin
        grant = SW'(j);
        any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hold_reg_sched.sv
// Round-robin scheduler that loads one requester's data into a shared hold register
// and enforces a minimum spacing of HOLD_CYCLES edges between loads.
module hold_reg_sched
  import hold_sched_pkg::*;
#(
  parameter int N_REQ       = N_REQ_DEF,
  parameter int DW          = DW_DEF,
  parameter int HOLD_CYCLES = HOLD_CYCLES_DEF
) (
  input  logic                     clock,
  input  logic                     resetN,
  input  logic                     clr,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ-1:0][DW-1:0] data,
  output logic [N_REQ-1:0]         ack,
  output logic [DW-1:0]            y,
  output logic                     y_valid,
  output logic [src_w(N_REQ)-1:0]  y_src,
  output hold_state_e              state_dbg
);

  localparam int SW = src_w(N_REQ);
  localparam int CW = $clog2(HOLD_CYCLES + 1);

  // Handshake: a requester holds req and data steady until it samples ack high;
  // ack is a one-cycle registered pulse and masks that requester for one edge.
  hold_state_e      state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [SW-1:0]    ptr_q, ptr_d;
  logic [N_REQ-1:0] elig;
  logic [SW-1:0]    g;
  logic             any_elig;
  logic             load;

  logic [DW-1:0]    y_d;
  logic [SW-1:0]    src_d;
  logic             valid_d;
  logic [N_REQ-1:0] ack_d;

  assign elig = req & ~ack;

  rr_pick #(
    .N  (N_REQ),
    .SW (SW)
  ) u_pick (
    .elig  (elig),
    .ptr   (ptr_q),
    .grant (g),
    .any   (any_elig)
  );

  assign load      = !clr && any_elig && ((state_q == IDLE) || (cnt_q == '0));
  assign state_dbg = state_q;

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    if (clr) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (load) begin
      state_d = HOLD;
      cnt_d   = CW'(HOLD_CYCLES - 1);
      ptr_d   = (g == SW'(N_REQ - 1)) ? '0 : g + SW'(1);
    end else if (state_q == HOLD) begin
      if (cnt_q != '0) cnt_d   = cnt_q - CW'(1);
      else             state_d = IDLE;
    end
  end

  // Next values for the output flops; without a load everything simply holds.
  always_comb begin
    y_d     = y;
    src_d   = y_src;
    valid_d = y_valid;
    ack_d   = '0;
    if (clr) begin
      y_d     = '0;
      src_d   = '0;
      valid_d = 1'b0;
    end else if (load) begin
      y_d     = data[g];
      src_d   = g;
      valid_d = 1'b1;
      ack_d   = N_REQ'(1) << g;
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      y       <= '0;
      y_src   <= '0;
      y_valid <= 1'b0;
      ack     <= '0;
    end else begin
      y       <= y_d;
      y_src   <= src_d;
      y_valid <= valid_d;
      ack     <= ack_d;
    end
  end

endmodule

// File: tb/tb_hold_reg_sched.sv
// Directed bench for hold_reg_sched: expected loads are queued as stimulus is issued
// and a monitor per DUT pops and compares on every ack pulse.
module tb_hold_reg_sched;
  import hold_sched_pkg::*;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int SW = 2;
  localparam int W  = SW + DW;

  // clock / reset
  logic clock;
  logic resetN;
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // DUT A: HOLD_CYCLES = 2
  logic                 clr_a;
  logic [N-1:0]         req_a;
  logic [N-1:0][DW-1:0] data_a;
  logic [N-1:0]         ack_a;
  logic [DW-1:0]        y_a;
  logic                 valid_a;
  logic [SW-1:0]        src_a;
  hold_state_e          state_a;

  // DUT B: HOLD_CYCLES = 1
  logic                 clr_b;
  logic [N-1:0]         req_b;
  logic [N-1:0][DW-1:0] data_b;
  logic [N-1:0]         ack_b;
  logic [DW-1:0]        y_b;
  logic                 valid_b;
  logic [SW-1:0]        src_b;
  hold_state_e          state_b;

  hold_reg_sched #(.N_REQ(N), .DW(DW), .HOLD_CYCLES(2)) dut_a (
    .clock(clock), .resetN(resetN), .clr(clr_a), .req(req_a), .data(data_a),
    .ack(ack_a), .y(y_a), .y_valid(valid_a), .y_src(src_a), .state_dbg(state_a)
  );

  hold_reg_sched #(.N_REQ(N), .DW(DW), .HOLD_CYCLES(1)) dut_b (
    .clock(clock), .resetN(resetN), .clr(clr_b), .req(req_b), .data(data_b),
    .ack(ack_b), .y(y_b), .y_valid(valid_b), .y_src(src_b), .state_dbg(state_b)
  );

  // scoreboard
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_b_q[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic mon_cmp(input string tag, input logic [W-1:0] e, input logic [N-1:0] ack,
                         input logic [DW-1:0] y, input logic [SW-1:0] src, input logic valid);
    logic [N-1:0] exp_ack;
    exp_ack = N'(1) << e[W-1:DW];
    check({tag, "_ack"}, 32'(ack), 32'(exp_ack));
    check({tag, "_y"}, 32'(y), 32'(e[DW-1:0]));
    check({tag, "_src"}, 32'(src), 32'(e[W-1:DW]));
    check({tag, "_valid"}, 32'(valid), 32'd1);
  endtask

  always @(negedge clock) begin
    if (ack_a != '0) begin
      if (exp_q.size() == 0) check("a_unexpected_ack", 32'(ack_a), 32'd0);
      else mon_cmp("a_load", exp_q.pop_front(), ack_a, y_a, src_a, valid_a);
    end
    if (ack_b != '0) begin
      if (exp_b_q.size() == 0) check("b_unexpected_ack", 32'(ack_b), 32'd0);
      else mon_cmp("b_load", exp_b_q.pop_front(), ack_b, y_b, src_b, valid_b);
    end
  end

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic issue_a(input int idx, input logic [DW-1:0] d);
    data_a[idx] = d;
    req_a       = N'(1) << idx;
    exp_q.push_back({SW'(idx), d});
  endtask

  initial begin
    resetN = 1'b0;
    clr_a  = 1'b0;  req_a = '0;  data_a = '0;
    clr_b  = 1'b0;  req_b = '0;  data_b = '0;
    step(2);
    check("rst_y", 32'(y_a), 32'd0);
    check("rst_valid", 32'(valid_a), 32'd0);
    check("rst_src", 32'(src_a), 32'd0);
    check("rst_ack", 32'(ack_a), 32'd0);
    check("rst_state", 32'(state_a), 32'(IDLE));
    check("rst_b_y", 32'(y_b), 32'd0);
    resetN = 1'b1;

    // full contention: loads every 2 edges, order 0,1,2,3,0
    for (int i = 0; i < N; i++) data_a[i] = DW'(i + 1);
    req_a = '1;
    for (int i = 0; i < 5; i++) exp_q.push_back({SW'(i % N), DW'((i % N) + 1)});
    step(2);
    check("rr_gap_ack", 32'(ack_a), 32'd0);
    step(7);
    req_a = '0;
    step(3);
    check("rr_idle_state", 32'(state_a), 32'(IDLE));

    // single request from requester 2
    issue_a(2, 8'h5A);
    step(1);
    req_a = '0;
    for (int i = 0; i < 4; i++) begin
      step(1);
      check("single_no_ack", 32'(ack_a), 32'd0);
      check("single_y", 32'(y_a), 32'h5A);
      check("single_src", 32'(src_a), 32'd2);
    end

    // hold with no requests
    issue_a(0, 8'h07);
    step(1);
    req_a = '0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      check("hold_y", 32'(y_a), 32'h07);
      check("hold_valid", 32'(valid_a), 32'd1);
      check("hold_ack", 32'(ack_a), 32'd0);
    end
    check("hold_state", 32'(state_a), 32'(IDLE));

    // clr collides with a request: clr wins, request granted next edge
    data_a[1] = 8'hC3;
    req_a     = 4'b0010;
    clr_a     = 1'b1;
    step(1);
    check("clr_y", 32'(y_a), 32'd0);
    check("clr_valid", 32'(valid_a), 32'd0);
    check("clr_src", 32'(src_a), 32'd0);
    check("clr_ack", 32'(ack_a), 32'd0);
    clr_a = 1'b0;
    exp_q.push_back({SW'(1), 8'hC3});
    step(1);
    req_a = '0;
    step(2);

    // asynchronous reset in the middle of a hold
    issue_a(2, 8'h11);
    step(1);
    req_a = '0;
    check("pre_rst_state", 32'(state_a), 32'(HOLD));
    #2 resetN = 1'b0;
    #1;
    check("mid_rst_y", 32'(y_a), 32'd0);
    check("mid_rst_valid", 32'(valid_a), 32'd0);
    check("mid_rst_src", 32'(src_a), 32'd0);
    check("mid_rst_ack", 32'(ack_a), 32'd0);
    check("mid_rst_state", 32'(state_a), 32'(IDLE));
    step(1);
    issue_a(3, 8'h9C);
    resetN = 1'b1;
    step(1);
    req_a = '0;
    step(2);

    // HOLD_CYCLES=1: back-to-back loads alternating 0,1
    data_b[0] = 8'hA0;
    data_b[1] = 8'hB1;
    req_b     = 4'b0011;
    for (int i = 0; i < 6; i++) exp_b_q.push_back({SW'(i % 2), (i % 2 == 0) ? 8'hA0 : 8'hB1});
    step(6);
    req_b = '0;
    step(3);

    check("a_queue_drained", 32'(exp_q.size()), 32'd0);
    check("b_queue_drained", 32'(exp_b_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
